serdiv_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `serdiv_wrapper` serial divider between `NUM_REQ` requesters. It captures one operation at a time, issues it to the divider via its valid/ready handshake, captures the result and its taint label, and returns them to the granted requester over a per-requester response handshake. It sits between the issue ports (e.g. integer and crypto units) and the single labelled divider instance.

---
 rtl/serdiv_arbiter_if.sv | 68 ++++++
 rtl/serdiv_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_serdiv_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serdiv_arbiter_if.sv
// Bundle of requester, response and divider handshake signals around the shared divider arbiter.
// The arbiter uses the slave view; the surrounding issue logic and divider use the master view.
interface serdiv_arbiter_if #(
    parameter int NUM_REQ       = 2,
    parameter int WIDTH         = 64,
    parameter int TRANS_ID_BITS = 3
);
    logic                                   flush_i;

    logic [NUM_REQ-1:0]                     req_vld_i;
    logic [NUM_REQ-1:0]                     req_rdy_o;
    logic [NUM_REQ-1:0][WIDTH-1:0]          req_op_a_i;
    logic [NUM_REQ-1:0][WIDTH-1:0]          req_op_b_i;
    logic [NUM_REQ-1:0]                     req_op_a_label_i;
    logic [NUM_REQ-1:0]                     req_op_b_label_i;
    logic [NUM_REQ-1:0][1:0]                req_opcode_i;
    logic [NUM_REQ-1:0][TRANS_ID_BITS-1:0]  req_id_i;

    logic [NUM_REQ-1:0]                     rsp_vld_o;
    logic [NUM_REQ-1:0]                     rsp_rdy_i;
    logic [WIDTH-1:0]                       rsp_res_o;
    logic                                   rsp_res_label_o;
    logic [TRANS_ID_BITS-1:0]               rsp_id_o;

    logic                                   div_in_vld_o;
    logic                                   div_in_rdy_i;
    logic [WIDTH-1:0]                       div_op_a_o;
    logic [WIDTH-1:0]                       div_op_b_o;
    logic                                   div_op_a_label_o;
    logic                                   div_op_b_label_o;
    logic [1:0]                             div_opcode_o;
    logic [TRANS_ID_BITS-1:0]               div_id_o;
    logic                                   div_flush_o;

    logic                                   div_out_vld_i;
    logic                                   div_out_rdy_o;
    logic [WIDTH-1:0]                       div_res_i;
    logic                                   div_res_label_i;
    logic [TRANS_ID_BITS-1:0]               div_id_i;

    modport slave (
        input  flush_i,
        input  req_vld_i, req_op_a_i, req_op_b_i, req_op_a_label_i, req_op_b_label_i,
        input  req_opcode_i, req_id_i,
        output req_rdy_o,
        output rsp_vld_o, rsp_res_o, rsp_res_label_o, rsp_id_o,
        input  rsp_rdy_i,
        output div_in_vld_o, div_op_a_o, div_op_b_o, div_op_a_label_o, div_op_b_label_o,
        output div_opcode_o, div_id_o, div_flush_o,
        input  div_in_rdy_i,
        input  div_out_vld_i, div_res_i, div_res_label_i, div_id_i,
        output div_out_rdy_o
    );

    modport master (
        output flush_i,
        output req_vld_i, req_op_a_i, req_op_b_i, req_op_a_label_i, req_op_b_label_i,
        output req_opcode_i, req_id_i,
        input  req_rdy_o,
        input  rsp_vld_o, rsp_res_o, rsp_res_label_o, rsp_id_o,
        output rsp_rdy_i,
        input  div_in_vld_o, div_op_a_o, div_op_b_o, div_op_a_label_o, div_op_b_label_o,
        input  div_opcode_o, div_id_o, div_flush_o,
        output div_in_rdy_i,
        output div_out_vld_i, div_res_i, div_res_label_i, div_id_i,
        input  div_out_rdy_o
    );
endinterface

// File: rtl/serdiv_arbiter.sv
// Round-robin arbiter sharing one labelled serial divider between NUM_REQ requesters,
// one operation in flight at a time.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a request; grants first valid at/after ptr
// ST_ISSUE | latched operation presented to the divider
// ST_BUSY  | divider working; waiting for its result
// ST_RESP  | result presented to the owning requester
module serdiv_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int WIDTH         = 64,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    serdiv_arbiter_if.slave    bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_BUSY, ST_RESP} state_e;

    state_e                   state_q, state_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic [PTR_W-1:0]         owner_q, owner_d;
    logic [WIDTH-1:0]         op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
    logic                     op_a_lbl_q, op_a_lbl_d, op_b_lbl_q, op_b_lbl_d;
    logic                     res_lbl_q, res_lbl_d;
    logic [1:0]               opcode_q, opcode_d;
    logic [TRANS_ID_BITS-1:0] id_q, id_d, rsp_id_q, rsp_id_d;
    logic                     div_in_vld_q, div_in_vld_d;
    logic                     div_out_rdy_q, div_out_rdy_d;
    logic [NUM_REQ-1:0]       rsp_vld_q, rsp_vld_d;

    logic                     gnt_vld;
    logic [PTR_W-1:0]         gnt_idx;
    logic [PTR_W-1:0]         cand_idx;
    logic [NUM_REQ-1:0]       gnt_oh;

    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    // Scan from the farthest offset back to ptr so the nearest valid requester wins.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        cand_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand_idx = rr_idx(ptr_q, i);
            if (bus.req_vld_i[cand_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand_idx;
            end
        end
        gnt_oh          = '0;
        gnt_oh[gnt_idx] = gnt_vld;
    end

    assign bus.req_rdy_o = (state_q == ST_IDLE && !bus.flush_i && !rst_i) ? gnt_oh : '0;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        op_a_lbl_d    = op_a_lbl_q;
        op_b_lbl_d    = op_b_lbl_q;
        opcode_d      = opcode_q;
        id_d          = id_q;
        res_d         = res_q;
        res_lbl_d     = res_lbl_q;
        rsp_id_d      = rsp_id_q;
        div_in_vld_d  = div_in_vld_q;
        div_out_rdy_d = div_out_rdy_q;
        rsp_vld_d     = rsp_vld_q;

        if (bus.flush_i) begin
            // Drop everything in flight; the round-robin pointer survives.
            state_d       = ST_IDLE;
            owner_d       = '0;
            op_a_d        = '0;
            op_b_d        = '0;
            op_a_lbl_d    = 1'b0;
            op_b_lbl_d    = 1'b0;
            opcode_d      = '0;
            id_d          = '0;
            res_d         = '0;
            res_lbl_d     = 1'b0;
            rsp_id_d      = '0;
            div_in_vld_d  = 1'b0;
            div_out_rdy_d = 1'b0;
            rsp_vld_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        owner_d      = gnt_idx;
                        op_a_d       = bus.req_op_a_i[gnt_idx];
                        op_b_d       = bus.req_op_b_i[gnt_idx];
                        op_a_lbl_d   = bus.req_op_a_label_i[gnt_idx];
                        op_b_lbl_d   = bus.req_op_b_label_i[gnt_idx];
                        opcode_d     = bus.req_opcode_i[gnt_idx];
                        id_d         = bus.req_id_i[gnt_idx];
                        ptr_d        = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
                        div_in_vld_d = 1'b1;
                        state_d      = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.div_in_rdy_i) begin
                        div_in_vld_d  = 1'b0;
                        div_out_rdy_d = 1'b1;
                        state_d       = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.div_out_vld_i) begin
                        res_d              = bus.div_res_i;
                        res_lbl_d          = bus.div_res_label_i;
                        rsp_id_d           = bus.div_id_i;
                        div_out_rdy_d      = 1'b0;
                        rsp_vld_d          = '0;
                        rsp_vld_d[owner_q] = 1'b1;
                        state_d            = ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_rdy_i[owner_q]) begin
                        rsp_vld_d = '0;
                        state_d   = ST_IDLE;
                    end
                end
                default: begin
                    div_in_vld_d  = 1'b0;
                    div_out_rdy_d = 1'b0;
                    rsp_vld_d     = '0;
                    state_d       = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            owner_q       <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            op_a_lbl_q    <= 1'b0;
            op_b_lbl_q    <= 1'b0;
            opcode_q      <= '0;
            id_q          <= '0;
            res_q         <= '0;
            res_lbl_q     <= 1'b0;
            rsp_id_q      <= '0;
            div_in_vld_q  <= 1'b0;
            div_out_rdy_q <= 1'b0;
            rsp_vld_q     <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            op_a_lbl_q    <= op_a_lbl_d;
            op_b_lbl_q    <= op_b_lbl_d;
            opcode_q      <= opcode_d;
            id_q          <= id_d;
            res_q         <= res_d;
            res_lbl_q     <= res_lbl_d;
            rsp_id_q      <= rsp_id_d;
            div_in_vld_q  <= div_in_vld_d;
            div_out_rdy_q <= div_out_rdy_d;
            rsp_vld_q     <= rsp_vld_d;
        end
    end

    assign bus.div_in_vld_o     = div_in_vld_q;
    assign bus.div_op_a_o       = op_a_q;
    assign bus.div_op_b_o       = op_b_q;
    assign bus.div_op_a_label_o = op_a_lbl_q;
    assign bus.div_op_b_label_o = op_b_lbl_q;
    assign bus.div_opcode_o     = opcode_q;
    assign bus.div_id_o         = id_q;
    assign bus.div_flush_o      = bus.flush_i;
    assign bus.div_out_rdy_o    = div_out_rdy_q;

    assign bus.rsp_vld_o        = rsp_vld_q;
    assign bus.rsp_res_o        = res_q;
    // Taint can only accumulate: any labelled operand taints the result.
    assign bus.rsp_res_label_o  = res_lbl_q | op_a_lbl_q | op_b_lbl_q;
    assign bus.rsp_id_o         = rsp_id_q;
endmodule

// File: tb/tb_serdiv_arbiter.sv
// Scoreboard bench for serdiv_arbiter with a behavioural divider stub of programmable latency.
module tb_serdiv_arbiter;
    localparam int NR  = 2;
    localparam int W   = 64;
    localparam int TIB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serdiv_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .TRANS_ID_BITS(TIB)) bus ();
    serdiv_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TRANS_ID_BITS(TIB)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int             owner;
        logic [63:0]    res;
        logic           lbl;
        logic [TIB-1:0] id;
    } exp_t;
    exp_t sbq[$];

    logic [63:0]    e_res [NR];
    logic           e_lbl [NR];
    logic [TIB-1:0] e_id  [NR];

    int   lat     = 1;
    logic ret_lbl = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Divider stub: accepts on in handshake, answers after lat cycles, cleared by flush/reset.
    initial begin : divider_stub
        logic [63:0]    s_a, s_b;
        logic [1:0]     s_opc;
        logic [TIB-1:0] s_id;
        logic           s_have, acc_in, acc_out, rs, fl;
        int             s_cnt;
        s_a = '0; s_b = '0; s_opc = '0; s_id = '0; s_have = 1'b0; s_cnt = 0;
        bus.div_out_vld_i   = 1'b0;
        bus.div_res_i       = '0;
        bus.div_res_label_i = 1'b0;
        bus.div_id_i        = '0;
        forever begin
            @(posedge clk);
            rs      = rst;
            fl      = bus.div_flush_o;
            acc_in  = bus.div_in_vld_o && bus.div_in_rdy_i;
            acc_out = bus.div_out_vld_i && bus.div_out_rdy_o;
            if (acc_in) begin
                s_a = bus.div_op_a_o; s_b = bus.div_op_b_o;
                s_opc = bus.div_opcode_o; s_id = bus.div_id_o;
            end
            #1;
            if (rs || fl) begin
                s_have = 1'b0;
                bus.div_out_vld_i = 1'b0;
            end else begin
                if (acc_out) begin
                    bus.div_out_vld_i = 1'b0;
                    s_have = 1'b0;
                end
                if (acc_in) begin
                    s_have = 1'b1;
                    s_cnt  = lat;
                end else if (s_have && !bus.div_out_vld_i) begin
                    if (s_cnt <= 0) begin
                        case (s_opc)
                            2'd0:    bus.div_res_i = s_a / s_b;
                            2'd1:    bus.div_res_i = $signed(s_a) / $signed(s_b);
                            2'd2:    bus.div_res_i = s_a % s_b;
                            default: bus.div_res_i = $signed(s_a) % $signed(s_b);
                        endcase
                        bus.div_res_label_i = ret_lbl;
                        bus.div_id_i        = s_id;
                        bus.div_out_vld_i   = 1'b1;
                    end else begin
                        s_cnt--;
                    end
                end
            end
        end
    end

    // Monitor: compares each completed response handshake against the head of the queue.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (bus.rsp_vld_o & bus.rsp_rdy_i) != '0) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: rsp_vld_o=%b with nothing expected at %0t",
                             bus.rsp_vld_o, $time);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_owner", 64'(bus.rsp_vld_o), 64'(1) << e.owner);
                    chk("rsp_res",   bus.rsp_res_o, e.res);
                    chk("rsp_label", 64'(bus.rsp_res_label_o), 64'(e.lbl));
                    chk("rsp_id",    64'(bus.rsp_id_o), 64'(e.id));
                end
            end
        end
    end

    task automatic set_req(input int r, input logic [63:0] a, input logic [63:0] b,
                           input logic la, input logic lb, input logic [1:0] opc,
                           input logic [TIB-1:0] id, input logic [63:0] eres, input logic elbl);
        bus.req_op_a_i[r]       = a;
        bus.req_op_b_i[r]       = b;
        bus.req_op_a_label_i[r] = la;
        bus.req_op_b_label_i[r] = lb;
        bus.req_opcode_i[r]     = opc;
        bus.req_id_i[r]         = id;
        bus.req_vld_i[r]        = 1'b1;
        e_res[r] = eres;
        e_lbl[r] = elbl;
        e_id[r]  = id;
    endtask

    task automatic wait_grant(input int r, input bit drop, input bit push);
        bit   got;
        exp_t e;
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.req_rdy_o != '0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            timeout_fail("grant_wait");
            return;
        end
        chk("grant_onehot", 64'(bus.req_rdy_o), 64'(1) << r);
        chk("pre_issue_idle", 64'(bus.div_in_vld_o), 64'd0);
        if (push) begin
            e.owner = r; e.res = e_res[r]; e.lbl = e_lbl[r]; e.id = e_id[r];
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        if (drop) bus.req_vld_i[r] = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 300 && sbq.size() > 0; k++) @(negedge clk);
        if (sbq.size() > 0) begin
            timeout_fail("drain");
            sbq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.div_out_rdy_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout_fail("busy_wait");
    endtask

    // {op_a_label, op_b_label, divider label, expected result label}
    logic [3:0] lbl_vec [5] = '{4'b0000, 4'b1001, 4'b0101, 4'b1101, 4'b0011};

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [3:0] v;
        bit         got;
        bus.flush_i          = 1'b0;
        bus.req_vld_i        = '0;
        bus.req_op_a_i       = '0;
        bus.req_op_b_i       = '0;
        bus.req_op_a_label_i = '0;
        bus.req_op_b_label_i = '0;
        bus.req_opcode_i     = '0;
        bus.req_id_i         = '0;
        bus.rsp_rdy_i        = '1;
        bus.div_in_rdy_i     = 1'b1;

        // Reset values, with a pending request and flush to show gating/pass-through.
        bus.req_vld_i = 2'b01;
        bus.flush_i   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_rdy",    64'(bus.req_rdy_o), 64'd0);
        chk("rst_flush_hi",   64'(bus.div_flush_o), 64'd1);
        bus.flush_i = 1'b0;
        #1;
        chk("rst_flush_lo",   64'(bus.div_flush_o), 64'd0);
        chk("rst_rsp_vld",    64'(bus.rsp_vld_o), 64'd0);
        chk("rst_in_vld",     64'(bus.div_in_vld_o), 64'd0);
        chk("rst_out_rdy",    64'(bus.div_out_rdy_o), 64'd0);
        chk("rst_op_a",       bus.div_op_a_o, 64'd0);
        chk("rst_rsp_res",    bus.rsp_res_o, 64'd0);
        bus.req_vld_i = '0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Single requester 0: 0x20/0x20 udiv.
        set_req(0, 64'h20, 64'h20, 1'b0, 1'b0, 2'd0, 3'd5, 64'd1, 1'b0);
        wait_grant(0, 1'b1, 1'b1);
        @(negedge clk);
        chk("t1_issue_lat", 64'(bus.div_in_vld_o), 64'd1);
        chk("t1_issue_op_a", bus.div_op_a_o, 64'h20);
        wait_drain();

        // Signed divide truncates toward zero: -20 / 3 = -6.
        set_req(0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 1'b0, 1'b0, 2'd1, 3'd7,
                64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
        wait_grant(0, 1'b1, 1'b1);
        wait_drain();

        // Fresh reset, then both requesters valid continuously: grants 0,1,0,1...
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        set_req(0, 64'd100, 64'd10, 1'b0, 1'b0, 2'd0, 3'd1, 64'd10, 1'b0);
        set_req(1, 64'd100, 64'd7,  1'b0, 1'b0, 2'd2, 3'd2, 64'd2,  1'b0);
        for (int i = 0; i < 8; i++) wait_grant(i % 2, (i >= 6), 1'b1);
        wait_drain();

        // Label propagation over operand and divider label combinations.
        for (int k = 0; k < 5; k++) begin
            v = lbl_vec[k];
            ret_lbl = v[1];
            set_req(0, 64'd9, 64'd3, v[3], v[2], 2'd0, TIB'(k), 64'd3, v[0]);
            wait_grant(0, 1'b1, 1'b1);
            wait_drain();
        end
        ret_lbl = 1'b0;

        // Backpressure on both divider input and response; no second grant meanwhile.
        bus.div_in_rdy_i = 1'b0;
        bus.rsp_rdy_i[0] = 1'b0;
        set_req(0, 64'd50, 64'd5, 1'b0, 1'b0, 2'd0, 3'd3, 64'd10, 1'b0);
        wait_grant(0, 1'b1, 1'b1);
        set_req(1, 64'd21, 64'd4, 1'b0, 1'b0, 2'd2, 3'd4, 64'd1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_vld",  64'(bus.div_in_vld_o), 64'd1);
            chk("bp_op_a",    bus.div_op_a_o, 64'd50);
            chk("bp_op_b",    bus.div_op_b_o, 64'd5);
            chk("bp_no_gnt",  64'(bus.req_rdy_o), 64'd0);
        end
        @(posedge clk);
        #1 bus.div_in_rdy_i = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.rsp_vld_o != '0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout_fail("bp_rsp_wait");
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_rsp_vld",  64'(bus.rsp_vld_o), 64'd1);
            chk("bp_rsp_res",  bus.rsp_res_o, 64'd10);
            chk("bp_rsp_nogn", 64'(bus.req_rdy_o), 64'd0);
        end
        @(posedge clk);
        #1 bus.rsp_rdy_i[0] = 1'b1;
        wait_grant(1, 1'b1, 1'b1);
        wait_drain();

        // Flush in BUSY: op discarded, ptr kept (last grant was 1, so 0 is aborted).
        lat = 6;
        set_req(0, 64'd77, 64'd7, 1'b0, 1'b0, 2'd0, 3'd6, 64'd11, 1'b0);
        wait_grant(0, 1'b1, 1'b0);
        wait_busy();
        @(posedge clk);
        #1 bus.flush_i = 1'b1;
        set_req(1, 64'd30, 64'd6, 1'b0, 1'b0, 2'd0, 3'd2, 64'd5, 1'b0);
        set_req(0, 64'd40, 64'd8, 1'b0, 1'b0, 2'd0, 3'd3, 64'd5, 1'b0);
        @(negedge clk);
        chk("fl_div_flush", 64'(bus.div_flush_o), 64'd1);
        chk("fl_same_cyc",  64'(bus.div_out_rdy_o), 64'd1);
        @(negedge clk);
        chk("fl_idle",      64'(bus.div_out_rdy_o), 64'd0);
        chk("fl_no_rsp",    64'(bus.rsp_vld_o), 64'd0);
        chk("fl_no_gnt",    64'(bus.req_rdy_o), 64'd0);
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
        lat = 1;
        wait_grant(1, 1'b1, 1'b1);
        wait_grant(0, 1'b1, 1'b1);
        wait_drain();

        // Async reset mid-BUSY: ptr was 1, first grant after release must be 0.
        lat = 6;
        set_req(0, 64'd60, 64'd6, 1'b1, 1'b0, 2'd0, 3'd5, 64'd10, 1'b1);
        wait_grant(0, 1'b1, 1'b0);
        wait_busy();
        #2 rst = 1'b1;
        #1;
        chk("ar_out_rdy", 64'(bus.div_out_rdy_o), 64'd0);
        chk("ar_in_vld",  64'(bus.div_in_vld_o), 64'd0);
        chk("ar_rsp_vld", 64'(bus.rsp_vld_o), 64'd0);
        chk("ar_op_a",    bus.div_op_a_o, 64'd0);
        chk("ar_label",   64'(bus.rsp_res_label_o), 64'd0);
        set_req(0, 64'd81, 64'd9, 1'b0, 1'b0, 2'd0, 3'd1, 64'd9, 1'b0);
        set_req(1, 64'd17, 64'd5, 1'b0, 1'b1, 2'd2, 3'd6, 64'd2, 1'b1);
        chk("ar_req_rdy", 64'(bus.req_rdy_o), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        lat = 1;
        wait_grant(0, 1'b1, 1'b1);
        wait_grant(1, 1'b1, 1'b1);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
